// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM read streamer.
// Ports: none (package only): FSM state enum and default address widths.
package ram_rd_pkg;

   localparam int WORDS = 256;
   localparam int AW    = $clog2(WORDS);
   localparam int LW    = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/ram_read_streamer_fifo2.sv
// Two-entry synchronous FIFO holding {last, data} beats.
// Ports: clk, rst_n, push_i/wdata_i in, pop_i in, rdata_o head, full_o, empty_o, count_o.
module fifo2 #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_q];

   // A pop frees the head slot in the same cycle, so push-while-full is fine then.
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata_i;
            wr_q        <= ~wr_q;
         end
         if (do_pop) begin
            rd_q <= ~rd_q;
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ram_read_streamer.sv
// Streams a block of RAM words out as a valid/ready stream with a last flag.
// Ports: start/base_addr/len command, busy/done status, ram_addr/ram_qout RAM side, m_* stream.
module ram_read_streamer
   import ram_rd_pkg::*;
#(
   parameter int DW    = 8,
   parameter int WORDS = 256,
   localparam int AW   = $clog2(WORDS),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_qout,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last
);

   state_e        state_q;
   logic [AW-1:0] addr_q;
   logic [LW-1:0] rem_q;
   logic          infl_q;
   logic          infl_last_q;
   logic          busy_q;
   logic          done_q;

   logic [1:0]    fcount;
   logic          fempty;
   logic          ffull;
   logic [DW:0]   fhead;
   logic          push;
   logic          pop;
   logic [2:0]    occ_d;
   logic          issue;
   logic          last_issue;
   logic          drain_ok;

   assign ram_addr = addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign m_valid  = ~fempty;
   assign m_data   = fhead[DW-1:0];
   assign m_last   = fhead[DW] & ~fempty;

   assign pop  = m_valid & m_ready;
   assign push = infl_q & (~ffull | pop);

   // Words already owed to the stream once this cycle's pop/landing settle.
   assign occ_d      = {1'b0, fcount} + {2'b00, infl_q} - {2'b00, pop};
   assign issue      = (state_q == ISSUE) && (occ_d < 3'd2);
   assign last_issue = issue && (rem_q == LW'(1));
   assign drain_ok   = ~infl_q &&
                       ((fcount == 2'd0) || ((fcount == 2'd1) && pop));

   fifo2 #(
      .W (DW + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({infl_last_q, ram_qout}),
      .rdata_o (fhead),
      .full_o  (ffull),
      .empty_o (fempty),
      .count_o (fcount)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         infl_q      <= issue;
         infl_last_q <= last_issue;
         done_q      <= 1'b0;
         if (issue) begin
            addr_q <= (addr_q == AW'(WORDS - 1)) ? '0 : addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= base_addr;
                  rem_q   <= len;
                  busy_q  <= 1'b1;
                  state_q <= (len == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (last_issue) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_ok) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               // Empty blocks skip DRAIN, so their pulse is raised from here.
               done_q  <= ~done_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Self-checking bench for ram_read_streamer against a queue-based block model.
// Ports: none (top-level testbench).
module tb_ram_read_streamer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic [8:0] len = '0;
   logic       busy;
   logic       done;
   logic [7:0] ram_addr;
   logic [7:0] ram_qout;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic       m_last;

   logic [7:0] mem [256];

   int cmp = 0;
   int mis = 0;

   always #5 clk = ~clk;

   // Registered-read RAM: data for an address appears one cycle later.
   always @(posedge clk) ram_qout <= mem[ram_addr];

   ram_read_streamer #(
      .DW    (8),
      .WORDS (256)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_qout  (ram_qout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_m_data"}, m_data, 0);
   endtask

   // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready.
   task automatic run_block(input int base, input int l, input int mode,
                            input bit inject, input int abort_at);
      int  expd[$];
      bit  expl[$];
      int  bpat[6] = '{1, 0, 0, 1, 0, 1};
      int  beats = 0;
      int  dones = 0;
      int  done_cyc = -1;
      int  after = 0;
      int  k = 0;
      int  occ;
      int  ex;
      bit  el;
      bit  prev_stall = 0;
      bit  seen_valid = 0;
      logic [7:0] pd = '0;
      logic       pl = 1'b0;
      for (int i = 0; i < l; i++) begin
         expd.push_back(int'(mem[(base + i) % 256]));
         expl.push_back(i == l - 1);
      end
      chk("idle_busy", busy, 0);
      start     = 1'b1;
      base_addr = base[7:0];
      len       = l[8:0];
      while (1) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         start = 1'b0;
         if (inject && k == 2) begin
            start     = 1'b1;
            base_addr = 8'd99;
            len       = 9'd3;
         end
         if (abort_at >= 0 && beats == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_vals("abort");
            @(negedge clk);
            rst_n   = 1'b1;
            m_ready = 1'b0;
            return;
         end
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (bpat[(k - 1) % 6] != 0);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (k == 1) chk("busy_c1", busy, 1);
         if (mode == 0 && k <= l) chk("ram_addr", ram_addr, (base + k - 1) % 256);
         occ = int'(dut.fcount) + int'(dut.infl_q);
         chk("occ_le2", 32'(occ <= 2), 1);
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, pd);
            chk("stall_last", m_last, pl);
         end
         if (m_valid) seen_valid = 1;
         if (m_valid && m_ready) begin
            if (expd.size() == 0) begin
               chk("extra_beat", beats + 1, l);
            end else begin
               ex = expd.pop_front();
               el = expl.pop_front();
               chk("beat_data", m_data, ex);
               chk("beat_last", m_last, el);
               if (mode == 0) chk("beat_cycle", k, beats + 3);
            end
            beats++;
         end
         prev_stall = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (done_cyc >= 0) after++;
         if (after >= 4) break;
         if (done_cyc < 0 && k > 8 * l + 20) begin
            chk("done_timeout", dones, 1);
            break;
         end
      end
      chk("beats", beats, l);
      chk("dones", dones, 1);
      if (mode == 0) chk("done_cycle", done_cyc, (l == 0) ? 2 : l + 3);
      if (l == 0) chk("no_valid", seen_valid, 0);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = i[7:0];
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_block(10, 4, 0, 0, -1);
      run_block(254, 4, 0, 0, -1);
      run_block(20, 8, 1, 0, -1);
      run_block(30, 0, 0, 0, -1);
      run_block(40, 5, 0, 1, -1);
      run_block(0, 256, 2, 0, -1);
      run_block(50, 8, 0, 0, 3);
      run_block(0, 2, 0, 0, -1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         run_block(int'($urandom_range(0, 255)), int'($urandom_range(1, 20)),
                   2, 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule

// File: doc/ram_read_streamer.md
Name: ram_read_streamer

Overview:
- Read-side companion of the project's simple dual-clock RAM; sits in the read-clock domain, drives the RAM read address and consumes its registered read data.
- On a start command, reads a block of words beginning at a base address.
- Presents the words as a valid/ready stream with a last flag.
- Absorbs the RAM's one-cycle read latency and downstream backpressure without losing or duplicating words.

Parameters:
- DW, 8, data width; must match the RAM's DW.
- WORDS, 256, RAM depth; AW = $clog2(WORDS), LW = AW+1.

Ports:
- clk  in  1  single clock (the RAM read clock).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only when busy=0.
- base_addr  in  AW  first word address, sampled with start.
- len  in  LW  word count 0..WORDS, sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse on block completion.
- ram_addr  out  AW  RAM read address.
- ram_qout  in  DW  RAM read data; corresponds to ram_addr of the previous cycle.
- m_data  out  DW  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final beat of a block.

Behaviour:
- Reset values: busy=0, done=0, ram_addr=0, m_valid=0, m_last=0, m_data=0. FSM goes to IDLE. Buffer and in-flight flags are cleared.
- Reset mid-block aborts the block. No done pulse is produced and buffered words are discarded.
- FSM states:
  - IDLE: start=1 with len>0 -> ISSUE, latching addr=base_addr and remaining=len. start=1 with len=0 -> DONE.
  - ISSUE: issues read addresses. After the final address is issued -> DRAIN.
  - DRAIN: waits until the in-flight read has landed and the buffer has emptied with the last beat handshaked -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in ISSUE, DRAIN and DONE; busy=0 in IDLE. start is ignored while busy=1.
- ram_addr is driven combinationally from the address counter. The counter increments only when a read is issued, wrapping modulo WORDS (addr WORDS-1 -> 0).
- Issue rule: let occ = buffer entries at the start of the cycle, infl = 1 if a read was issued the previous cycle, pop = m_valid & m_ready.
  - Issue a read in ISSUE when occ + infl - pop < 2.
- Read data: a read issued in cycle N is captured from ram_qout at the end of cycle N+1 into a 2-entry FIFO.
  - Capture only happens when that read was issued (in-flight flag). Otherwise ram_qout is ignored.
- m_valid = FIFO non-empty. m_data and m_last come from the FIFO head. m_last is stored per entry: set on the entry for the final word.
- Words leave in address order. No drop, no duplicate. Push and pop in the same cycle are legal.
- Latency: start high in cycle 0 -> ram_addr=base in cycle 1 -> m_valid=1 in cycle 3.
- With m_ready held at 1, throughput is one beat per cycle and a block of L words ends with done in cycle L+3.
- Backpressure: while m_ready=0, m_data, m_valid and m_last stay stable. At most 2 words are held (1 buffered + 1 in flight, or 2 buffered).
- len=WORDS reads every word exactly once, starting at base_addr.
- len=0 produces no beats. done is pulsed in cycle 2: start in cycle 0, DONE in cycle 1, done registered.

Decomposition:
- Package ram_rd_pkg:
  - state_e enum {IDLE, ISSUE, DRAIN, DONE}.
  - Localparams AW and LW computed from WORDS.
- Sub-module fifo2: 2-entry synchronous FIFO of width DW+1 (data plus last flag), using clk and rst_n.
  - Signals: push, pop, full, empty, count.
  - Simultaneous push and pop while full is legal.
- The top level holds the FSM, the address and remaining counters, and the in-flight flag.

Test Plan:
- Streaming: RAM preloaded with mem[i]=i; start with base=10, len=4, m_ready=1.
  - Required: beats 10, 11, 12, 13 on consecutive cycles 3..6; m_last on 13; done one pulse.
- Wrap: base=254, len=4, WORDS=256.
  - Required: ram_addr sequence 254, 255, 0, 1; data 254, 255, 0, 1.
- Backpressure: len=8; m_ready toggles 1,0,0,1,0,1,...
  - Required: all 8 words in order, no duplicates, data stable while stalled; in-flight plus buffered never exceeds 2.
- Zero length and ignored start:
  - len=0 -> done pulse, no m_valid.
  - start re-asserted while busy -> ignored; block output unchanged.
- Full depth: len=256, base=0, random m_ready.
  - Required: 256 beats 0..255, m_last only on the last.
- Reset mid-block: assert rst_n=0 after 3 beats.
  - Required: all outputs go to reset values immediately. A new start with base=0, len=2 then yields beats 0, 1 and done.
